// File: rtl/miriscv_mdu_if.sv
// Request/result handshake between the execute stage and the multiply/divide unit.
interface miriscv_mdu_if #(
  parameter int XLEN = 32
);
  logic            mdu_req_i;
  logic [2:0]      mdu_op_i;
  logic [XLEN-1:0] mdu_port_a_i;
  logic [XLEN-1:0] mdu_port_b_i;
  logic            mdu_kill_i;
  logic            mdu_busy_o;
  logic            mdu_valid_o;
  logic [XLEN-1:0] mdu_result_o;

  modport master (
    output mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
    input  mdu_busy_o, mdu_valid_o, mdu_result_o
  );

  modport slave (
    input  mdu_req_i, mdu_op_i, mdu_port_a_i, mdu_port_b_i, mdu_kill_i,
    output mdu_busy_o, mdu_valid_o, mdu_result_o
  );
endinterface

// File: rtl/miriscv_mdu.sv
// Sequential RV32M/RV64M multiply/divide unit: 2-cycle multiply, radix-2 restoring
// divider with early exit for divide-by-zero and signed overflow.
module miriscv_mdu #(
  parameter int XLEN = 32
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  miriscv_mdu_if.slave   mdu
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q, rem_q, res_q, out_q;
  logic             neg_quot_q, neg_rem_q;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? (XLEN'(0) - v) : v;
  endfunction

  // Request decode, only meaningful while IDLE
  logic            accept, is_div, sgn_div, is_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign accept   = mdu.mdu_req_i & ~mdu.mdu_kill_i;
  assign is_div   = mdu.mdu_op_i[2];
  assign sgn_div  = ~mdu.mdu_op_i[0];
  assign is_rem   = mdu.mdu_op_i[1];
  assign a_neg    = sgn_div & mdu.mdu_port_a_i[XLEN-1];
  assign b_neg    = sgn_div & mdu.mdu_port_b_i[XLEN-1];
  assign div_zero = (mdu.mdu_port_b_i == '0);
  assign div_ovf  = sgn_div && (mdu.mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}})
                            && (mdu.mdu_port_b_i == '1);
  assign special_res = div_zero ? (is_rem ? mdu.mdu_port_a_i : '1)
                                : (is_rem ? '0 : mdu.mdu_port_a_i);

  // Multiplier: operands widened so one signed product covers all four forms
  logic            sgn_a, sgn_b;
  logic signed [2*XLEN-1:0] ext_a, ext_b, prod;

  assign sgn_a = (op_q != 2'b11);
  assign sgn_b = ~op_q[1];
  assign ext_a = {{XLEN{sgn_a & a_q[XLEN-1]}}, a_q};
  assign ext_b = {{XLEN{sgn_b & b_q[XLEN-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Restoring step: a_q doubles as the dividend/quotient shift register
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_step;

  assign shifted  = {rem_q, a_q[XLEN-1]};
  assign ge       = (shifted >= {1'b0, b_q});
  assign rem_step = shifted[XLEN-1:0] - b_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (!is_div)                   state_d = S_MUL;
        else if (div_zero || div_ovf)  state_d = S_DONE;
        else                           state_d = S_DIV;
      end
      S_MUL:  state_d = S_DONE;
      S_DIV:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && mdu.mdu_kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      out_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          op_q       <= mdu.mdu_op_i[1:0];
          a_q        <= is_div ? neg_if(a_neg, mdu.mdu_port_a_i) : mdu.mdu_port_a_i;
          b_q        <= is_div ? neg_if(b_neg, mdu.mdu_port_b_i) : mdu.mdu_port_b_i;
          rem_q      <= '0;
          cnt_q      <= CNT_W'(XLEN-1);
          neg_quot_q <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          if (is_div) res_q <= special_res;
        end
        S_MUL: res_q <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        S_DIV: begin
          a_q   <= {a_q[XLEN-2:0], ge};
          rem_q <= ge ? rem_step : shifted[XLEN-1:0];
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: res_q <= op_q[1] ? neg_if(neg_rem_q, rem_q) : neg_if(neg_quot_q, a_q);
        S_DONE: if (!mdu.mdu_kill_i) out_q <= res_q;
        default: ;
      endcase
    end
  end

  // A killed result never reaches out_q, so the visible result stays put
  assign mdu.mdu_busy_o   = (state_q != S_IDLE);
  assign mdu.mdu_valid_o  = (state_q == S_DONE) & ~mdu.mdu_kill_i;
  assign mdu.mdu_result_o = (state_q == S_DONE) ? res_q : out_q;
endmodule

// File: tb/tb_miriscv_mdu.sv
// Scoreboard bench for miriscv_mdu at XLEN=32 and XLEN=64: directed corner cases,
// kill/reset/back-to-back scenarios, then random operations against an arithmetic model.
module tb_miriscv_mdu;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  miriscv_mdu_if #(.XLEN(32)) if32();
  miriscv_mdu_if #(.XLEN(64)) if64();

  miriscv_mdu #(.XLEN(32)) u_mdu32 (.clk_i(clk), .arstn_i(arstn), .mdu(if32));
  miriscv_mdu #(.XLEN(64)) u_mdu64 (.clk_i(clk), .arstn_i(arstn), .mdu(if64));

  typedef struct {
    logic [63:0] res;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] last_res[2];

  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int width(input int d);
    return (d == 0) ? 32 : 64;
  endfunction

  // Reference: plain signed/unsigned arithmetic at 130 bits, truncated to w
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
    logic [63:0] m;
    logic signed [129:0] au, bu, as, bs, p, minv;
    m    = mask(w);
    au   = $signed({66'd0, a & m});
    bu   = $signed({66'd0, b & m});
    as   = a[w-1] ? au - (130'sd1 <<< w) : au;
    bs   = b[w-1] ? bu - (130'sd1 <<< w) : bu;
    minv = -(130'sd1 <<< (w-1));
    p    = 0;
    case (op)
      3'd0: p = as * bs;
      3'd1: p = (as * bs) >>> w;
      3'd2: p = (as * bu) >>> w;
      3'd3: p = (au * bu) >>> w;
      3'd4: p = (bu == 0) ? -1 : ((as == minv && bs == -1) ? as : as / bs);
      3'd5: p = (bu == 0) ? -1 : au / bu;
      3'd6: p = (bu == 0) ? as : ((as == minv && bs == -1) ? 0 : as % bs);
      default: p = (bu == 0) ? au : au % bu;
    endcase
    return p[63:0] & m;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [63:0] a,
                                     input logic [63:0] b, input int w);
    logic [63:0] m, mn;
    m  = mask(w);
    mn = 64'd1 << (w - 1);
    if (!op[2]) return 2;
    if ((b & m) == 64'd0) return 1;
    if (!op[0] && (a & m) == mn && (b & m) == m) return 1;
    return w + 2;
  endfunction

  function automatic logic busy(input int d);
    return (d == 0) ? if32.mdu_busy_o : if64.mdu_busy_o;
  endfunction

  function automatic logic valid(input int d);
    return (d == 0) ? if32.mdu_valid_o : if64.mdu_valid_o;
  endfunction

  function automatic logic [63:0] result(input int d);
    return (d == 0) ? {32'd0, if32.mdu_result_o} : if64.mdu_result_o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int d, input logic req, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
    if (d == 0) begin
      if32.mdu_req_i = req; if32.mdu_op_i = op;
      if32.mdu_port_a_i = a[31:0]; if32.mdu_port_b_i = b[31:0];
    end else begin
      if64.mdu_req_i = req; if64.mdu_op_i = op;
      if64.mdu_port_a_i = a; if64.mdu_port_b_i = b;
    end
  endtask

  task automatic set_req(input int d, input logic v);
    if (d == 0) if32.mdu_req_i = v; else if64.mdu_req_i = v;
  endtask

  task automatic set_kill(input int d, input logic v);
    if (d == 0) if32.mdu_kill_i = v; else if64.mdu_kill_i = v;
  endtask

  task automatic push(input int d, input logic [63:0] res, input int t0, input int lat);
    exp_t e;
    e.res = res; e.t0 = t0; e.lat = lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (busy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy(d)) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout dut%0d: busy stuck at 1, want 0", d);
    end
  endtask

  // Leaves the request high at the negedge of cycle 0
  task automatic start(input int d, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit chk);
    wait_idle(d);
    set_in(d, 1'b1, op, a, b);
    if (chk) push(d, exp, cyc, exp_latency(op, a, b, width(d)));
  endtask

  task automatic issue(input int d, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp);
    start(d, op, a, b, exp, 1'b1);
    @(negedge clk);
    set_req(d, 1'b0);
  endtask

  task automatic mon_step(input int d);
    exp_t e;
    if (!valid(d)) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_valid dut%0d: valid=1 result=%h, want no valid", d, result(d));
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("result_dut%0d", d), result(d), e.res);
    check($sformatf("latency_dut%0d", d), 64'(cyc - e.t0), 64'(e.lat));
    last_res[d] = e.res;
  endtask

  initial forever begin @(negedge clk); #1; mon_step(0); end
  initial forever begin @(negedge clk); #1; mon_step(1); end

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m, mn;
    m  = mask(w);
    mn = 64'd1 << (w - 1);
    case ($urandom_range(0, 24))
      0: return 64'd0;
      1: return 64'd1;
      2: return m;
      3: return mn;
      4: return mn - 64'd1;
      default: return {$urandom(), $urandom()} & m;
    endcase
  endfunction

  task automatic run_random(input int d, input int n);
    logic [2:0]  op;
    logic [63:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick(width(d));
      b  = pick(width(d));
      issue(d, op, a, b, ref_model(op, a, b, width(d)));
    end
  endtask

  initial begin
    set_in(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_in(1, 1'b0, 3'd0, 64'd0, 64'd0);
    set_kill(0, 1'b0);
    set_kill(1, 1'b0);
    last_res[0] = 64'd0;
    last_res[1] = 64'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy(0)}, 64'd0);
    check("reset_valid", {63'd0, valid(0)}, 64'd0);
    check("reset_result", result(0), 64'd0);
    check("reset_busy64", {63'd0, busy(1)}, 64'd0);
    arstn = 1'b1;

    // Multiply forms and division cases
    issue(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000);
    issue(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
    issue(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    issue(0, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0001);
    issue(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF);
    issue(0, 3'd5, 64'd100, 64'd7, 64'd14);
    issue(0, 3'd7, 64'd100, 64'd7, 64'd2);
    issue(0, 3'd4, 64'd55, 64'd0, 64'hFFFF_FFFF);
    issue(0, 3'd7, 64'h1234, 64'd0, 64'h1234);
    issue(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
    issue(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
    issue(1, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000);
    issue(1, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV -7/2 with busy profile across cycles 1..35
    start(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 1'b1);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) set_req(0, 1'b0);
      #1;
      check($sformatf("busy_div_c%0d", k), {63'd0, busy(0)}, (k <= 34) ? 64'd1 : 64'd0);
    end

    // Kill during division cycle 10, then a normal request
    start(0, 3'd5, 64'd100, 64'd7, 64'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) set_req(0, 1'b0);
    end
    set_kill(0, 1'b1);
    @(negedge clk);
    set_kill(0, 1'b0);
    #1;
    check("kill_busy", {63'd0, busy(0)}, 64'd0);
    check("kill_valid", {63'd0, valid(0)}, 64'd0);
    check("kill_result", result(0), last_res[0]);
    issue(0, 3'd5, 64'd200, 64'd9, 64'd22);

    // Kill in the DONE cycle of a special case masks the valid pulse
    start(0, 3'd4, 64'd9, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0);
    set_kill(0, 1'b1);
    #1;
    check("kill_done_valid", {63'd0, valid(0)}, 64'd0);
    @(negedge clk);
    set_kill(0, 1'b0);
    #1;
    check("kill_done_busy", {63'd0, busy(0)}, 64'd0);
    check("kill_done_result", result(0), last_res[0]);

    // Kill together with a request in IDLE drops the request
    wait_idle(0);
    set_in(0, 1'b1, 3'd0, 64'd3, 64'd5);
    set_kill(0, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0);
    set_kill(0, 1'b0);
    #1;
    check("kill_idle_busy", {63'd0, busy(0)}, 64'd0);

    // Request held high: MUL, then DIVU accepted in the cycle after the MUL valid
    begin
      int t0;
      start(0, 3'd0, 64'd6, 64'd7, 64'd42, 1'b1);
      t0 = cyc;
      @(negedge clk);
      set_in(0, 1'b1, 3'd5, 64'd100, 64'd7);
      push(0, 64'd14, t0 + 3, 34);
      repeat (3) @(negedge clk);
      set_req(0, 1'b0);
    end

    // Requests raised mid-division are ignored
    issue(0, 3'd7, 64'd1000, 64'd33, 64'd10);
    repeat (4) @(negedge clk);
    set_in(0, 1'b1, 3'd0, 64'd2, 64'd2);
    repeat (3) @(negedge clk);
    set_req(0, 1'b0);

    // Asynchronous reset mid-MUL
    start(0, 3'd0, 64'd11, 64'd13, 64'd0, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0);
    arstn = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy(0)}, 64'd0);
    check("arst_valid", {63'd0, valid(0)}, 64'd0);
    check("arst_result", result(0), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    last_res[0] = 64'd0;
    last_res[1] = 64'd0;

    fork
      run_random(0, 800);
      run_random(1, 500);
    join

    for (int i = 0; i < 3000 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL missing_results: %0d/%0d outstanding, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
